// File: rtl/fifo_pkg.sv
// Shared state type and sizing for the FIFO read-side stream engine.
package fifo_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} rd_state_e;

    localparam int SKID_DEPTH = 2;

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry in-order skid buffer holding words captured from the FIFO.
// Latency: a pushed word reaches the head the cycle after the push edge.
// Backpressure: none internally; the caller's credit rule keeps pushes off a full buffer.
module fifo_skid_buf
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_dat_i,
    input  logic                  pop_i,
    output logic [1:0]            occ_o,
    output logic [DATA_WIDTH-1:0] head_dat_o
);

    logic [DATA_WIDTH-1:0] mem_q [SKID_DEPTH];
    logic                  wr_ptr_q;
    logic                  rd_ptr_q;
    logic [1:0]            occ_q;
    logic [1:0]            occ_d;

    always_comb begin
        occ_d = occ_q;
        case ({push_i, pop_i})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= push_dat_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_i) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            occ_q <= occ_d;
        end
    end

    assign occ_o      = occ_q;
    assign head_dat_o = mem_q[rd_ptr_q];

    // A capture landing on a full buffer would silently drop a word.
    assert property (@(posedge clk) disable iff (rst)
        !(push_i && occ_q == 2'(SKID_DEPTH)));

endmodule

// File: rtl/fifo_rd_stream.sv
// Drains fifo_syn onto a valid/ready stream; word_cnt exists only with FIFO_RD_CNT_EN.
// Latency: first word RD_LATENCY+1 cycles after enable is sampled with the FIFO non-empty.
// Backpressure: m_ready low holds m_data; reads stop while buffered+in-flight words reach two.
module fifo_rd_stream
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int RD_LATENCY = 1
`ifdef FIFO_RD_CNT_EN
    , parameter int CNT_W    = 16
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data_out,
    output logic                  fifo_cs,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    output logic                  busy
`ifdef FIFO_RD_CNT_EN
    , output logic [CNT_W-1:0]    word_cnt
`endif
);

    rd_state_e             state_q;
    rd_state_e             state_d;
    logic [RD_LATENCY-1:0] infl_q;
    logic [RD_LATENCY-1:0] infl_d;
    logic [1:0]            occ;
    logic [2:0]            credit_used;
    logic                  capture;
    logic                  pop;

    // Credit counts words already buffered plus words still travelling from the FIFO.
    assign credit_used = {1'b0, occ} + 3'($countones(infl_q));
    assign fifo_rd_en  = (state_q == RUN) && enable && !fifo_empty
                         && (credit_used < 3'(SKID_DEPTH));
    assign fifo_cs     = fifo_rd_en;
    assign infl_d      = (infl_q << 1) | RD_LATENCY'(fifo_rd_en);
    assign capture     = infl_q[RD_LATENCY-1];
    assign m_valid     = (occ != 2'd0);
    assign pop         = m_valid && m_ready;
    assign busy        = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (enable) state_d = RUN;
            end
            RUN: begin
                if (!enable) state_d = (infl_q != '0 || occ != 2'd0) ? DRAIN : IDLE;
            end
            DRAIN: begin
                if (enable)                              state_d = RUN;
                else if (infl_q == '0 && occ == 2'd0)    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            infl_q  <= '0;
        end else begin
            state_q <= state_d;
            infl_q  <= infl_d;
        end
    end

    fifo_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk        (clk),
        .rst        (rst),
        .push_i     (capture),
        .push_dat_i (fifo_data_out),
        .pop_i      (pop),
        .occ_o      (occ),
        .head_dat_o (m_data)
    );

`ifdef FIFO_RD_CNT_EN
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign cnt_d = pop ? cnt_q + CNT_W'(1) : cnt_q;

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign word_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream with a behavioural fifo_syn (DEPTH 8, read latency 1).
module tb_fifo_rd_stream;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          fifo_empty;
    logic [DW-1:0] fifo_data_out = '0;
    logic          fifo_cs;
    logic          fifo_rd_en;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_ready;
    logic          busy;
`ifdef FIFO_RD_CNT_EN
    localparam int CW = 3;
    logic [CW-1:0] word_cnt;
`endif

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] fmem [8];
    int            wr_cnt = 0;
    int            rd_cnt = 0;
    logic [DW-1:0] exp_q [$];

    fifo_rd_stream #(
        .DATA_WIDTH (DW),
        .RD_LATENCY (1)
`ifdef FIFO_RD_CNT_EN
        , .CNT_W    (CW)
`endif
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .fifo_empty    (fifo_empty),
        .fifo_data_out (fifo_data_out),
        .fifo_cs       (fifo_cs),
        .fifo_rd_en    (fifo_rd_en),
        .m_valid       (m_valid),
        .m_data        (m_data),
        .m_ready       (m_ready),
        .busy          (busy)
`ifdef FIFO_RD_CNT_EN
        , .word_cnt    (word_cnt)
`endif
    );

    always #5 clk = ~clk;

    assign fifo_empty = (wr_cnt == rd_cnt);

    always @(posedge clk) begin
        if (fifo_cs && fifo_rd_en) begin
            fifo_data_out <= fmem[rd_cnt[2:0]];
            rd_cnt        <= rd_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [DW-1:0] v);
        fmem[wr_cnt[2:0]] = v;
        wr_cnt++;
        exp_q.push_back(v);
    endtask

    task automatic drain(input string tag, input bit toggle);
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
            tick();
            if (toggle) m_ready = ~m_ready;
        end
        chk(tag, 32'(exp_q.size()), 32'd0);
        m_ready = 1'b1;
    endtask

    // Stream monitor: ordering, hold-while-stalled, no read on empty, two-word credit.
    int            issued    = 0;
    int            delivered = 0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_dat   = '0;

    always @(negedge clk) begin
        if (rst) begin
            issued     = 0;
            delivered  = 0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk1("hold_vld", m_valid, 1'b1);
                chk("hold_dat", m_data, prev_dat);
            end
            if (fifo_empty) chk1("rden_on_empty", fifo_rd_en, 1'b0);
            if (fifo_rd_en) chk1("credit", (issued - delivered) < 2, 1'b1);
            if (m_valid && m_ready) begin
                chk1("sb_has_word", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) chk("sb_data", m_data, exp_q.pop_front());
                delivered++;
            end
            if (fifo_rd_en) issued++;
            prev_stall = m_valid && !m_ready;
            prev_dat   = m_data;
        end
    end

    initial begin
        rst     = 1'b1;
        enable  = 1'b0;
        m_ready = 1'b0;
        tick();
        tick();
        chk1("rst_rd_en", fifo_rd_en, 1'b0);
        chk1("rst_cs", fifo_cs, 1'b0);
        chk1("rst_m_valid", m_valid, 1'b0);
        chk("rst_m_data", m_data, 32'd0);
        chk1("rst_busy", busy, 1'b0);
`ifdef FIFO_RD_CNT_EN
        chk("rst_word_cnt", 32'(word_cnt), 32'd0);
`endif
        rst = 1'b0;
        tick();

        // 1: four words, sink always ready
        for (int v = 1; v <= 4; v++) write_word(32'(v));
        m_ready = 1'b1;
        enable  = 1'b1;
        tick();
        chk1("t1_busy", busy, 1'b1);
        chk1("t1_rd_en", fifo_rd_en, 1'b1);
        tick();
        chk1("t1_no_valid_yet", m_valid, 1'b0);
        tick();
        chk1("t1_first_valid", m_valid, 1'b1);
        chk("t1_first_data", m_data, 32'd1);
        drain("t1_drain", 1'b0);
        enable = 1'b0;
        tick();
        chk1("t1_busy_drop", busy, 1'b0);

        // 2: full FIFO with toggling sink
        for (int v = 0; v < 8; v++) write_word(32'(v));
        m_ready = 1'b1;
        enable  = 1'b1;
        drain("t2_drain", 1'b1);
        enable = 1'b0;
        tick();
        chk1("t2_busy_drop", busy, 1'b0);

        // 3: empty FIFO while running, then one word arrives
        enable = 1'b1;
        tick();
        tick();
        tick();
        chk1("t3_rd_en_idle", fifo_rd_en, 1'b0);
        chk1("t3_m_valid", m_valid, 1'b0);
        chk1("t3_busy_run", busy, 1'b1);
        write_word(32'd9);
        tick();
        chk1("t3_valid_early", m_valid, 1'b0);
        tick();
        chk1("t3_valid", m_valid, 1'b1);
        chk("t3_data", m_data, 32'd9);
        tick();
        chk1("t3_consumed", m_valid, 1'b0);

        // 4: drop enable with one word buffered and one in flight
        m_ready = 1'b0;
        write_word(32'd20);
        write_word(32'd21);
        write_word(32'd22);
        tick();
        tick();
        chk1("t4_buffered", m_valid, 1'b1);
        chk1("t4_credit_stall", fifo_rd_en, 1'b0);
        enable = 1'b0;
        tick();
        chk1("t4_drain_busy", busy, 1'b1);
        chk1("t4_drain_no_rd", fifo_rd_en, 1'b0);
        chk("t4_head", m_data, 32'd20);
        m_ready = 1'b1;
        tick();
        tick();
        chk1("t4_still_drain", busy, 1'b1);
        chk1("t4_emptied", m_valid, 1'b0);
        tick();
        chk1("t4_idle", busy, 1'b0);
        chk1("t4_no_rd", fifo_rd_en, 1'b0);

        // 5: reset with the skid buffer full
        m_ready = 1'b0;
        write_word(32'd30);
        write_word(32'd31);
        enable = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk1("t5_full_valid", m_valid, 1'b1);
        chk("t5_full_head", m_data, 32'd22);
        chk1("t5_full_no_rd", fifo_rd_en, 1'b0);
        rst = 1'b1;
        tick();
        chk1("t5_rst_valid", m_valid, 1'b0);
        chk1("t5_rst_busy", busy, 1'b0);
        chk1("t5_rst_rd_en", fifo_rd_en, 1'b0);
        chk("t5_rst_data", m_data, 32'd0);
`ifdef FIFO_RD_CNT_EN
        chk("t5_rst_cnt", 32'(word_cnt), 32'd0);
`endif
        exp_q.delete();
        exp_q.push_back(32'd31);
        rst    = 1'b0;
        enable = 1'b0;
        tick();

        // 6: ten deliveries after reset
        m_ready = 1'b1;
        for (int v = 40; v <= 44; v++) write_word(32'(v));
        enable = 1'b1;
        drain("t6_drain_a", 1'b0);
`ifdef FIFO_RD_CNT_EN
        chk("t6_cnt_6", 32'(word_cnt), 32'd6);
`endif
        for (int v = 45; v <= 48; v++) write_word(32'(v));
        drain("t6_drain_b", 1'b0);
`ifdef FIFO_RD_CNT_EN
        chk("t6_cnt_wrap", 32'(word_cnt), 32'd2);
`endif
        enable = 1'b0;
        tick();
        chk1("t6_idle", busy, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
